duty_sequencer: RTL and testbench
=================================

DUTY_SEQUENCER -- requirements
Module: duty_sequencer

Interface
REQ-001 Parameter CH, default 2: number of duty channels.
REQ-002 Parameter DW, default 6: bits per channel duty value.
REQ-003 Parameter AW, default 8: address width; depth DEPTH = 2^AW.
REQ-004 Parameter STEP_W, default 12: playback step period is 2^STEP_W clocks.
REQ-005 Parameter CLR_VAL, default 32: value written to every channel by the clear operation.
REQ-006 sysclk  in  1  sole clock, all state on rising edge.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 Clear  in  1  level; starts the clear operation.
REQ-009 Rec_En  in  1  level; enables recording.
REQ-010 Capture  in  1  level button; rising edge stores one frame.
REQ-011 Play_En  in  1  level; enables playback.
REQ-012 Loop_Mode  in  1  1 = loop playback, 0 = play once.
REQ-013 Duty_In  in  CH*DW  live duties; channel k at bits [k*DW +: DW].
REQ-014 DC_Out  out  CH*DW  registered duty output, same packing.
REQ-015 Length  out  AW+1  number of stored frames, 0..DEPTH.
REQ-016 Play_Idx  out  AW  current playback frame index.
REQ-017 Busy  out  1  high while clearing.
REQ-018 Full  out  1  high when Length == DEPTH.
REQ-019 Done  out  1  high in state DONE.

Function
REQ-020 The FSM SHALL have states IDLE, CLEARING, PLAYING, DONE; Clear has priority over all other inputs in every state.
REQ-021 Clear high in any state: enter CLEARING next cycle; Length <= 0; Play_Idx <= 0.
REQ-022 CLEARING: write CLR_VAL to all channels at addresses 0..DEPTH-1, one per cycle, DEPTH cycles total; then go to IDLE; Capture/Play_En ignored.
REQ-023 Capture edge = Capture high this cycle and low the previous cycle (one internal register).
REQ-024 In IDLE with Rec_En=1, a Capture edge writes Duty_In to address Length[AW-1:0] and increments Length by 1.
REQ-025 A Capture edge while Full=1, while Rec_En=0, or in any state other than IDLE is discarded; Length saturates at DEPTH.
REQ-026 IDLE -> PLAYING when Play_En=1, Rec_En=0, Length>0; Play_Idx <= 0, step counter <= 0; with Length=0 the block stays in IDLE.
REQ-027 PLAYING: the STEP_W-bit step counter increments every cycle; when it is all ones, Play_Idx advances.
REQ-028 At advance with Play_Idx == Length-1: Loop_Mode=1 -> Play_Idx <= 0; Loop_Mode=0 -> state DONE, Play_Idx held.
REQ-029 DONE holds the last frame until Play_En=0, then goes to IDLE with Play_Idx <= 0.
REQ-030 PLAYING with Play_Enat 0 -> IDLE next cycle, Play_Idx <= 0, step counter <= 0.
REQ-031 DC_Out SHALL be registered with 1-cycle latency: mem[Play_Idx] in PLAYING/DONE; Duty_In in IDLE; CLR_VAL in CLEARING.
REQ-032 Rec_En has no effect outside IDLE; Loop_Mode is sampled at each wrap decision only.
REQ-033 Busy = (state == CLEARING); Done = (state == DONE); Full = (Length == DEPTH).

Reset
REQ-034 Reset_n low SHALL asynchronously set: state IDLE, Length 0, Play_Idx 0, step counter 0, clear address 0, capture-edge register 0, DC_Out all channels CLR_VAL.
REQ-035 Memory contents are not reset; reset mid-clear leaves the memory partially cleared with Length 0.

Structure
REQ-036 A shared package duty_seq_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-037 Storage SHALL be one sub-module duty_seq_mem: simple dual-port, CH*DW wide, DEPTH deep, one synchronous write port, one synchronous read port.

Verification (CH=2, DW=6, AW=3, STEP_W=2)
REQ-038 Clear pulse -> Busy high 8 cycles; afterwards all 8 addresses read 32; Length=0.
REQ-039 Rec_En=1; three Capture edges with Duty_In {5,10},{20,30},{40,50} -> Length=3; a Capture held high for 10 cycles counts once.
REQ-040 Play_En=1, Loop_Mode=0 -> DC_Out shows frames 0,1,2 for 4 cycles each, then Done=1 holding {40,50}; Play_En=0 -> IDLE, DC_Out tracks Duty_In.
REQ-041 Loop_Mode=1 -> sequence 0,1,2,0,1 with Play_Idx wrapping after index 2; Play_En dropped mid-step -> IDLE next cycle.
REQ-042 Nine Capture edges -> Length=8, Full=1; ninth edge ignored; address 0 unchanged.
REQ-043 Reset_n asserted during PLAYING and during CLEARING -> immediate IDLE, Length 0, DC_Out {32,32}.

Source files
------------

// File: rtl/duty_seq_pkg.sv
// duty_seq_pkg -- shared types and default constants for the duty sequencer.
//   state_e      : sequencer FSM state encoding
//   DEF_*        : default parameter values used by duty_sequencer
package duty_seq_pkg;

  localparam int DEF_CH      = 2;
  localparam int DEF_DW      = 6;
  localparam int DEF_AW      = 8;
  localparam int DEF_STEP_W  = 12;
  localparam int DEF_CLR_VAL = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEARING = 2'd1,
    ST_PLAYING  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/duty_seq_mem.sv
// duty_seq_mem -- simple dual-port frame store, no reset on contents.
//   clk_i          : clock
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i        : read address
//   rdata_o        : registered read data (mem[raddr_i] one clock later)
module duty_seq_mem #(
  parameter int W  = 12,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/duty_sequencer.sv
// duty_sequencer -- records frames of per-channel duty values and plays them
// back one frame per 2^STEP_W clocks, once or looped.
//   sysclk, Reset_n : clock, async active-low reset
//   Clear           : start clearing all frames to CLR_VAL (highest priority)
//   Rec_En, Capture : record; each Capture rising edge stores Duty_In
//   Play_En, Loop_Mode : playback control
//   Duty_In         : live duties, channel k at [k*DW +: DW]
//   DC_Out          : duty output, one clock behind the selecting state
//   Length, Play_Idx, Busy, Full, Done : status
module duty_sequencer
  import duty_seq_pkg::*;
#(
  parameter int CH      = DEF_CH,
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int STEP_W  = DEF_STEP_W,
  parameter int CLR_VAL = DEF_CLR_VAL
) (
  input  logic             sysclk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             Rec_En,
  input  logic             Capture,
  input  logic             Play_En,
  input  logic             Loop_Mode,
  input  logic [CH*DW-1:0] Duty_In,
  output logic [CH*DW-1:0] DC_Out,
  output logic [AW:0]      Length,
  output logic [AW-1:0]    Play_Idx,
  output logic             Busy,
  output logic             Full,
  output logic             Done
);

  localparam int                 DEPTH    = 1 << AW;
  localparam logic [DW-1:0]      CLR_CH   = DW'(CLR_VAL);
  localparam logic [CH*DW-1:0]   CLR_WORD = {CH{CLR_CH}};

  state_e              state_q;
  logic [AW:0]         len_q;
  logic [AW-1:0]       idx_q;
  logic [STEP_W-1:0]   step_q;
  logic [AW-1:0]       clr_addr_q;
  logic                cap_q;
  logic                src_mem_q;   // 1: output comes from the frame store
  logic [CH*DW-1:0]    alt_q;       // Duty_In or CLR_VAL, captured alongside

  logic                cap_edge;
  logic                full;
  logic                rec_wr;
  logic                clr_wr;
  logic [AW-1:0]       last_idx;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [CH*DW-1:0]    mem_wdata;
  logic [CH*DW-1:0]    mem_rdata;

  assign cap_edge = Capture & ~cap_q;
  assign full     = (len_q == (AW+1)'(DEPTH));
  assign last_idx = AW'(len_q - 1'b1);

  // Rec_En=1 blocks the IDLE->PLAYING branch, so a capture never races a start.
  assign rec_wr = (state_q == ST_IDLE) && !Clear && Rec_En && cap_edge && !full;
  assign clr_wr = (state_q == ST_CLEARING) && !Clear;

  always_comb begin
    mem_we    = rec_wr | clr_wr;
    mem_waddr = len_q[AW-1:0];
    mem_wdata = Duty_In;
    if (state_q == ST_CLEARING) begin
      mem_waddr = clr_addr_q;
      mem_wdata = CLR_WORD;
    end
  end

  duty_seq_mem #(
    .W  (CH*DW),
    .AW (AW)
  ) u_mem (
    .clk_i   (sysclk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      step_q     <= '0;
      clr_addr_q <= '0;
      cap_q      <= 1'b0;
      src_mem_q  <= 1'b0;
      alt_q      <= CLR_WORD;
    end else begin
      cap_q     <= Capture;
      // Output source follows the state of the previous cycle; the store's
      // read register supplies the frame with the same one-clock delay.
      src_mem_q <= (state_q == ST_PLAYING) || (state_q == ST_DONE);
      alt_q     <= (state_q == ST_CLEARING) ? CLR_WORD : Duty_In;

      if (Clear) begin
        state_q    <= ST_CLEARING;
        len_q      <= '0;
        idx_q      <= '0;
        step_q     <= '0;
        clr_addr_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (Play_En && !Rec_En && (len_q != '0)) begin
              state_q <= ST_PLAYING;
              idx_q   <= '0;
              step_q  <= '0;
            end else if (rec_wr) begin
              len_q <= len_q + 1'b1;
            end
          end
          ST_CLEARING: begin
            clr_addr_q <= clr_addr_q + 1'b1;
            if (&clr_addr_q) state_q <= ST_IDLE;
          end
          ST_PLAYING: begin
            if (!Play_En) begin
              state_q <= ST_IDLE;
              idx_q   <= '0;
              step_q  <= '0;
            end else begin
              step_q <= step_q + 1'b1;
              if (&step_q) begin
                if (idx_q == last_idx) begin
                  if (Loop_Mode) idx_q   <= '0;
                  else           state_q <= ST_DONE;
                end else begin
                  idx_q <= idx_q + 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
            if (!Play_En) begin
              state_q <= ST_IDLE;
              idx_q   <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign DC_Out   = src_mem_q ? mem_rdata : alt_q;
  assign Length   = len_q;
  assign Play_Idx = idx_q;
  assign Busy     = (state_q == ST_CLEARING);
  assign Full     = full;
  assign Done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_duty_sequencer.sv
// tb_duty_sequencer -- directed stimulus, a frame-level reference model that
// is compared against every output each cycle, and hand-computed checkpoints.
module tb_duty_sequencer;

  localparam int DEP   = 8;
  localparam int STEPS = 4;
  localparam logic [11:0] CLRW = 12'h820;

  logic        sysclk = 1'b0;
  logic        Reset_n, Clear, Rec_En, Capture, Play_En, Loop_Mode;
  logic [11:0] Duty_In;
  logic [11:0] DC_Out;
  logic [3:0]  Length;
  logic [2:0]  Play_Idx;
  logic        Busy, Full, Done;

  always #5 sysclk = ~sysclk;

  duty_sequencer #(
    .CH(2), .DW(6), .AW(3), .STEP_W(2), .CLR_VAL(32)
  ) u_dut (
    .sysclk    (sysclk),
    .Reset_n   (Reset_n),
    .Clear     (Clear),
    .Rec_En    (Rec_En),
    .Capture   (Capture),
    .Play_En   (Play_En),
    .Loop_Mode (Loop_Mode),
    .Duty_In   (Duty_In),
    .DC_Out    (DC_Out),
    .Length    (Length),
    .Play_Idx  (Play_Idx),
    .Busy      (Busy),
    .Full      (Full),
    .Done      (Done)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [11:0] pk(input int c0, input int c1);
    return {6'(c1), 6'(c0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // modes: 0 idle, 1 clearing, 2 playing, 3 done
  int          m_st = 0, m_len = 0, m_idx = 0, m_tick = 0, m_clr = 0;
  bit          m_cap = 0, m_edge;
  logic [11:0] m_mem [DEP];
  logic [11:0] m_dc = CLRW;

  task automatic model_step();
    if (!Reset_n) begin
      m_st = 0; m_len = 0; m_idx = 0; m_tick = 0; m_clr = 0; m_cap = 0; m_dc = CLRW;
      return;
    end
    m_edge = Capture && !m_cap;
    m_cap  = Capture;
    if (m_st == 2 || m_st == 3) m_dc = m_mem[m_idx];
    else if (m_st == 1)         m_dc = CLRW;
    else                        m_dc = Duty_In;
    if (Clear) begin
      m_st = 1; m_len = 0; m_idx = 0; m_clr = 0; m_tick = 0;
      return;
    end
    case (m_st)
      0: begin
        if (Play_En && !Rec_En && m_len > 0) begin
          m_st = 2; m_idx = 0; m_tick = 0;
        end else if (Rec_En && m_edge && m_len < DEP) begin
          m_mem[m_len] = Duty_In;
          m_len++;
        end
      end
      1: begin
        m_mem[m_clr] = CLRW;
        m_clr++;
        if (m_clr == DEP) begin m_st = 0; m_clr = 0; end
      end
      2: begin
        if (!Play_En) begin
          m_st = 0; m_idx = 0; m_tick = 0;
        end else begin
          m_tick++;
          if (m_tick == STEPS) begin
            m_tick = 0;
            if (m_idx == m_len - 1) begin
              if (Loop_Mode) m_idx = 0;
              else           m_st  = 3;
            end else m_idx++;
          end
        end
      end
      default: begin
        if (!Play_En) begin m_st = 0; m_idx = 0; end
      end
    endcase
  endtask

  initial forever begin
    @(posedge sysclk or negedge Reset_n);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge sysclk);
    chk("DC_Out",   DC_Out,   m_dc);
    chk("Length",   Length,   m_len);
    chk("Play_Idx", Play_Idx, m_idx);
    chk("Busy",     Busy,     (m_st == 1));
    chk("Done",     Done,     (m_st == 3));
    chk("Full",     Full,     (m_len == DEP));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic cap(input int a, input int b, input int hold);
    Duty_In = pk(a, b);
    Capture = 1'b1;
    tick(hold);
    Capture = 1'b0;
    tick(1);
  endtask

  logic [11:0] s [20];
  logic        d [20];
  logic [2:0]  ix [20];
  int          busy_n;

  initial begin
    Reset_n = 1'b1; Clear = 0; Rec_En = 0; Capture = 0; Play_En = 0; Loop_Mode = 0;
    Duty_In = '0;
    #1 Reset_n = 1'b0;
    tick(3);
    chk("reset_len", Length, 0);
    chk("reset_dc",  DC_Out, pk(32, 32));
    Reset_n = 1'b1;
    tick(1);

    // clear: Busy for 8 cycles, all addresses 32
    Clear = 1; tick(1); Clear = 0;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (Busy) busy_n++;
    end
    chk("clear_busy_cycles", busy_n, 8);
    for (int i = 0; i < DEP; i++) chk("clear_mem", u_dut.u_mem.mem_q[i], pk(32, 32));
    chk("clear_len", Length, 0);
    tick(1);

    // record three frames, the last with Capture held 10 cycles
    Rec_En = 1;
    cap(5, 10, 1);
    cap(20, 30, 1);
    cap(40, 50, 10);
    chk("rec_len", Length, 3);
    Rec_En = 0;

    // play once
    Duty_In = pk(1, 2); Loop_Mode = 0; Play_En = 1;
    for (int j = 0; j < 16; j++) begin
      @(negedge sysclk);
      s[j] = DC_Out; d[j] = Done;
    end
    chk("once_s1",  s[1],  pk(1, 2));
    chk("once_s3",  s[3],  pk(5, 10));
    chk("once_s5",  s[5],  pk(5, 10));
    chk("once_s6",  s[6],  pk(20, 30));
    chk("once_s9",  s[9],  pk(20, 30));
    chk("once_s10", s[10], pk(40, 50));
    chk("once_d12", d[12], 0);
    chk("once_d13", d[13], 1);
    chk("once_s15", s[15], pk(40, 50));
    Play_En = 0; Duty_In = pk(7, 9);
    tick(2);
    chk("after_done_dc",   DC_Out, pk(7, 9));
    chk("after_done_done", Done, 0);

    // loop playback, then drop Play_En mid-step
    Loop_Mode = 1; Play_En = 1;
    for (int j = 0; j < 19; j++) begin
      @(negedge sysclk);
      s[j] = DC_Out; ix[j] = Play_Idx;
    end
    chk("loop_i10", ix[10], 2);
    chk("loop_i14", ix[14], 0);
    chk("loop_i18", ix[18], 1);
    chk("loop_s12", s[12], pk(40, 50));
    chk("loop_s15", s[15], pk(5, 10));
    Play_En = 0;
    @(negedge sysclk);
    chk("stop_idx",  Play_Idx, 0);
    chk("stop_done", Done, 0);
    @(negedge sysclk);
    chk("stop_dc", DC_Out, pk(7, 9));
    tick(1);

    // fill to capacity
    Clear = 1; tick(1); Clear = 0; tick(9);
    Rec_En = 1;
    for (int i = 0; i < DEP; i++) cap(i + 1, 2 * i + 3, 1);
    cap(60, 61, 1);
    chk("full_len",  Length, 8);
    chk("full_flag", Full, 1);
    chk("full_mem0", u_dut.u_mem.mem_q[0], pk(1, 3));
    chk("full_mem7", u_dut.u_mem.mem_q[7], pk(8, 17));
    Rec_En = 0;

    // reset while playing
    Play_En = 1; Loop_Mode = 1;
    tick(6);
    chk("play_idx_pre_rst", Play_Idx, 1);
    Reset_n = 0; #1;
    chk("rst_play_len", Length, 0);
    chk("rst_play_idx", Play_Idx, 0);
    chk("rst_play_dc",  DC_Out, pk(32, 32));
    tick(1); Reset_n = 1; Play_En = 0; tick(2);

    // reset while clearing: memory partially cleared
    Clear = 1; tick(1); Clear = 0; tick(2);
    chk("clr_busy_pre_rst", Busy, 1);
    Reset_n = 0; #1;
    chk("rst_clr_busy", Busy, 0);
    chk("rst_clr_len",  Length, 0);
    chk("rst_clr_dc",   DC_Out, pk(32, 32));
    tick(1); Reset_n = 1; tick(2);
    chk("part_mem0", u_dut.u_mem.mem_q[0], pk(32, 32));
    chk("part_mem1", u_dut.u_mem.mem_q[1], pk(32, 32));
    chk("part_mem2", u_dut.u_mem.mem_q[2], pk(3, 7));
    chk("part_mem7", u_dut.u_mem.mem_q[7], pk(8, 17));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
